// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences machine-mode trap entry and MRET return through one CSR write port.
// Latency: trap accepted at T -> csr_req T+1..T+4 (ack high), redirect_v T+5, idle T+6; MRET redirect T+2.
// Backpressure: each CSR write holds until csr_ack; busy_o stalls issue. Optional feature macro: VECTORED_IRQ_EN.
module trap_ctrl #(
    parameter int          XLEN      = 32,
    parameter logic [11:0] MEPC_A    = 12'h341,
    parameter logic [11:0] MCAUSE_A  = 12'h342,
    parameter logic [11:0] MTVAL_A   = 12'h343,
    parameter logic [11:0] MSTATUS_A = 12'h300
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_v,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_v,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_tmr,
    input  logic [XLEN-1:0] next_pc,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            csr_req,
    output logic [11:0]     csr_adr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic            csr_ack,
    output logic            flush_o,
    output logic            busy_o,
    output logic            redirect_v,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_EPC    = 3'd1,
        W_CAUSE  = 3'd2,
        W_TVAL   = 3'd3,
        W_STAT   = 3'd4,
        REDIR    = 3'd5,
        W_STAT_R = 3'd6,
        REDIR_R  = 3'd7
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] stat_q;

    // mstatus image written on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [XLEN-1:0] trap_stat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus image written on MRET: MIE <- MPIE, MPIE <- 1, MPP stays M (M-only core).
    function automatic logic [XLEN-1:0] mret_stat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Interrupt is pending only if the line, its enable and global MIE are all set.
    logic irq_ext_p;
    logic irq_sw_p;
    logic irq_tmr_p;
    logic irq_any;

    assign irq_ext_p = irq_ext & mie_i[11] & mstatus_i[3];
    assign irq_sw_p  = irq_sw  & mie_i[3]  & mstatus_i[3];
    assign irq_tmr_p = irq_tmr & mie_i[7]  & mstatus_i[3];
    assign irq_any   = irq_ext_p | irq_sw_p | irq_tmr_p;

    // Highest-priority pending interrupt code: external, then software, then timer.
    logic [4:0] irq_code;
    always_comb begin
        irq_code = 5'd0;
        if (irq_ext_p) begin
            irq_code = 5'd11;
        end else if (irq_sw_p) begin
            irq_code = 5'd3;
        end else if (irq_tmr_p) begin
            irq_code = 5'd7;
        end
    end

    // Accept decision, only in IDLE: exception beats interrupt beats MRET.
    logic idle;
    logic acc_exc;
    logic acc_irq;
    logic acc_mret;
    logic acc_trap;

    assign idle     = (state_q == IDLE);
    assign acc_exc  = idle & exc_v;
    assign acc_irq  = idle & ~exc_v & irq_any;
    assign acc_mret = idle & ~exc_v & ~irq_any & mret_v;
    assign acc_trap = acc_exc | acc_irq;

    // Values captured on trap accept.
    logic [XLEN-1:0] acc_cause;
    logic [XLEN-1:0] acc_pc;
    logic [XLEN-1:0] acc_tval;

    assign acc_cause = acc_exc ? {{(XLEN-5){1'b0}}, exc_cause}
                               : {1'b1, {(XLEN-6){1'b0}}, irq_code};
    assign acc_pc    = acc_exc ? exc_pc : next_pc;
    assign acc_tval  = acc_exc ? exc_tval : '0;

    // Trap target: aligned mtvec base, optionally offset by 4*code for vectored interrupts.
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_tgt;

    assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_IRQ_EN
    assign trap_tgt = (cause_q[XLEN-1] && (mtvec_i[1:0] == 2'b01))
                    ? trap_base + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00}
                    : trap_base;
    logic unused_mie_bits;
    assign unused_mie_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
`else
    assign trap_tgt = trap_base;
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{mtvec_i[1:0], mie_i[XLEN-1:12], mie_i[10:8],
                               mie_i[6:4], mie_i[2:0]};
`endif

    // The accept cycle itself flushes; the sequencer is still IDLE there.
    assign flush_o = ~rst & (acc_trap | acc_mret);
    assign busy_o  = (state_q != IDLE);

    // Sequencer: one state per CSR write, each held until acked, then a single redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            tval_q      <= '0;
            stat_q      <= '0;
            csr_req     <= 1'b0;
            csr_adr     <= '0;
            csr_wdata   <= '0;
            redirect_v  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect_v <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acc_trap) begin
                        cause_q   <= acc_cause;
                        tval_q    <= acc_tval;
                        stat_q    <= mstatus_i;
                        csr_req   <= 1'b1;
                        csr_adr   <= MEPC_A;
                        csr_wdata <= acc_pc;
                        state_q   <= W_EPC;
                    end else if (acc_mret) begin
                        stat_q    <= mstatus_i;
                        csr_req   <= 1'b1;
                        csr_adr   <= MSTATUS_A;
                        csr_wdata <= mret_stat(mstatus_i);
                        state_q   <= W_STAT_R;
                    end
                end
                W_EPC: begin
                    if (csr_ack) begin
                        csr_adr   <= MCAUSE_A;
                        csr_wdata <= cause_q;
                        state_q   <= W_CAUSE;
                    end
                end
                W_CAUSE: begin
                    if (csr_ack) begin
                        csr_adr   <= MTVAL_A;
                        csr_wdata <= tval_q;
                        state_q   <= W_TVAL;
                    end
                end
                W_TVAL: begin
                    if (csr_ack) begin
                        csr_adr   <= MSTATUS_A;
                        csr_wdata <= trap_stat(stat_q);
                        state_q   <= W_STAT;
                    end
                end
                W_STAT: begin
                    if (csr_ack) begin
                        csr_req     <= 1'b0;
                        redirect_v  <= 1'b1;
                        redirect_pc <= trap_tgt;
                        state_q     <= REDIR;
                    end
                end
                REDIR: begin
                    state_q <= IDLE;
                end
                W_STAT_R: begin
                    if (csr_ack) begin
                        csr_req     <= 1'b0;
                        redirect_v  <= 1'b1;
                        redirect_pc <= mepc_i;
                        state_q     <= REDIR_R;
                    end
                end
                REDIR_R: begin
                    state_q <= IDLE;
                end
                default: begin
                    csr_req <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
